esp32_spi_connector: RTL and testbench

//  SPI slave (3-wire, mode 0) linking an ESP32 host to the FPGA core. It runs in the

---
 rtl/esp32_spi_connector_pkg.sv | 35 +++
 rtl/esp32_spi_connector_if.sv | 13 +
 rtl/esp32_spi_connector_byte_shifter.sv | 95 +++++++++
 rtl/esp32_spi_connector.sv | 184 ++++++++++++++++++
 tb/tb_esp32_spi_connector.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/esp32_spi_connector_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esp32_spi_pkg : shared frame states, protocol constants, CRC-8 helper. Rev 1.0
// ----------------------------------------------------------------------------
package esp32_spi_pkg;

  typedef enum logic [3:0] {
    ST_HUNT, ST_SYNC1, ST_OPC, ST_WDATA, ST_RDATA, ST_SUB0, ST_A0, ST_A1,
    ST_A2, ST_L0, ST_L1, ST_XWR, ST_XDUMMY, ST_XRD, ST_XCRC
  } frame_state_t;

  localparam logic [7:0] SYNC_B0   = 8'hA5;
  localparam logic [7:0] SYNC_B1   = 8'h5A;
  localparam logic [6:0] XFER_OPC  = 7'h7F;
  localparam logic [7:0] PROTO_VER = 8'h01;
  localparam logic [7:0] DEV_ID    = 8'hA2;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int SUB0_DIR       = 0;
  localparam int SUB0_SPACE_LSB = 1;
  localparam int SUB0_SPACE_MSB = 3;
  localparam int SUB0_INC       = 4;
  localparam int SUB0_CRC       = 5;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/esp32_spi_connector_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esp32_spi_connector_if : 3-wire SPI bundle between ESP32 host and FPGA. Rev 1.0
// ----------------------------------------------------------------------------
interface esp32_spi_connector_if;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output sclk, output mosi, input miso);
  modport slave  (input sclk, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/esp32_spi_connector_byte_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_byte_shifter : oversampled SPI mode-0 bit engine with idle timeout. Rev 1.0
// ----------------------------------------------------------------------------
module spi_byte_shifter #(
  parameter int IDLE_TO_CYC = 5_400_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_tx_load,
  input  logic [7:0] i_tx_data,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_idle_to,
  output logic       o_miso
);

  localparam int              CNT_W       = $clog2(IDLE_TO_CYC + 1);
  localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_TO_CYC - 1);
  localparam logic [CNT_W-1:0] C_IDLE_MAX  = CNT_W'(IDLE_TO_CYC);

  logic [2:0]       r_sclk_sync;
  logic [1:0]       r_mosi_sync;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_rx_sh;
  logic [7:0]       r_tx_sh;
  logic             r_byte_vld;
  logic             r_miso;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             w_rise;
  logic             w_fall;
  logic             w_idle_to;

  assign w_rise    = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_fall    = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_idle_to = !(w_rise || w_fall) && (r_idle_cnt == C_IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
      // Counter saturates so the timeout fires once per idle period
      if (w_rise || w_fall) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt != C_IDLE_MAX) begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_rx_sh    <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= w_rise && (r_bit_cnt == 3'd7);
      if (w_idle_to) begin
        r_bit_cnt <= '0;
      end else if (w_rise) begin
        r_rx_sh   <= {r_rx_sh[6:0], r_mosi_sync[1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sh <= '0;
      r_miso  <= 1'b0;
    end else begin
      r_miso <= r_tx_sh[7];
      if (w_idle_to) begin
        r_tx_sh <= '0;
      end else if (i_tx_load) begin
        r_tx_sh <= i_tx_data;
      end else if (w_fall && (r_bit_cnt != 3'd0)) begin
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end
    end
  end

  assign o_byte_vld = r_byte_vld;
  assign o_byte     = r_rx_sh;
  assign o_idle_to  = w_idle_to;
  assign o_miso     = r_miso;

endmodule
`default_nettype wire

// File: rtl/esp32_spi_connector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esp32_spi_connector : SPI slave with register map and 256-byte XFER portal. Rev 1.0
// ----------------------------------------------------------------------------
module esp32_spi_connector
  import esp32_spi_pkg::*;
#(
  parameter int USE_SYNC    = 1,
  parameter int USE_CRC     = 0,
  parameter int IDLE_TO_CYC = 5_400_000
) (
  input  logic                  clk,
  input  logic                  rst,
  esp32_spi_connector_if.slave  spi
);

  frame_state_t r_state, w_state_nxt;
  logic        w_byte_vld, w_idle_to, w_tx_load, w_miso;
  logic [7:0]  w_byte, w_tx_data, w_reg_rdata, w_rd_byte;
  logic        w_at_opc, w_crc_on, w_len_last, w_mem_we, w_scratch_wr;
  logic [6:0]  r_reg;
  logic        r_dir, r_inc, r_crc_en, r_crc_err;
  logic [2:0]  r_space;
  logic [7:0]  r_addr;
  logic [15:0] r_len;
  logic [7:0]  r_crc;
  logic [7:0]  r_scratch [16];
  logic [7:0]  r_mem [256];
  logic [7:0]  r_mem_q;

  spi_byte_shifter #(.IDLE_TO_CYC(IDLE_TO_CYC)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_sclk     (spi.sclk),
    .i_mosi     (spi.mosi),
    .i_tx_load  (w_tx_load),
    .i_tx_data  (w_tx_data),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte),
    .o_idle_to  (w_idle_to),
    .o_miso     (w_miso)
  );
  assign spi.miso = w_miso;

  assign w_at_opc     = (r_state == ST_OPC) || ((r_state == ST_HUNT) && (USE_SYNC == 0));
  assign w_crc_on     = (USE_CRC != 0) && r_crc_en;
  assign w_len_last   = (r_len == 16'd1);
  assign w_rd_byte    = (r_space == 3'd0) ? r_mem_q : 8'h00;
  assign w_scratch_wr = (r_reg[6:4] == 3'd0) && (r_reg[3:0] >= 4'h6);
  assign w_mem_we     = w_byte_vld && !w_idle_to && !rst && (r_state == ST_XWR) && (r_space == 3'd0);

  always_comb begin
    w_reg_rdata = 8'h00;
    if (w_byte[6:0] == 7'h00)      w_reg_rdata = DEV_ID;
    else if (w_byte[6:0] == 7'h04) w_reg_rdata = PROTO_VER;
    else if (w_byte[6:0] == 7'h05) w_reg_rdata = {7'd0, r_crc_err};
    else if ((w_byte[6:4] == 3'd0) && (w_byte[3:0] >= 4'h6)) w_reg_rdata = r_scratch[w_byte[3:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_load   = 1'b0;
    w_tx_data   = 8'h00;
    if (w_idle_to) begin
      w_state_nxt = ST_HUNT;
    end else if (w_byte_vld) begin
      if (w_at_opc) begin
        if (w_byte[6:0] == XFER_OPC) begin
          w_state_nxt = ST_SUB0;
        end else if (w_byte[7]) begin
          w_state_nxt = ST_RDATA;
          w_tx_load   = 1'b1;
          w_tx_data   = w_reg_rdata;
        end else begin
          w_state_nxt = ST_WDATA;
        end
      end else begin
        case (r_state)
          ST_HUNT:  if (w_byte == SYNC_B0) w_state_nxt = ST_SYNC1;
          ST_SYNC1: begin
            if (w_byte == SYNC_B1)      w_state_nxt = ST_OPC;
            else if (w_byte != SYNC_B0) w_state_nxt = ST_HUNT;
          end
          ST_SUB0:  w_state_nxt = ST_A0;
          ST_A0:    w_state_nxt = ST_A1;
          ST_A1:    w_state_nxt = ST_A2;
          ST_A2:    w_state_nxt = ST_L0;
          ST_L0:    w_state_nxt = ST_L1;
          ST_L1: begin
            if ({w_byte, r_len[7:0]} == 16'd0) w_state_nxt = ST_HUNT;
            else if (r_dir)                    w_state_nxt = ST_XDUMMY;
            else                               w_state_nxt = ST_XWR;
          end
          ST_XDUMMY: begin
            w_state_nxt = ST_XRD;
            w_tx_load   = 1'b1;
            w_tx_data   = w_rd_byte;
          end
          ST_XRD: begin
            if (!w_len_last) begin
              w_tx_load = 1'b1;
              w_tx_data = w_rd_byte;
            end else if (w_crc_on) begin
              w_state_nxt = ST_XCRC;
              w_tx_load   = 1'b1;
              w_tx_data   = r_crc;
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end
          ST_XWR: begin
            if (w_len_last) w_state_nxt = w_crc_on ? ST_XCRC : ST_HUNT;
          end
          default: w_state_nxt = ST_HUNT;
        endcase
      end
    end
  end

  // Only addr[7:0] reaches the 256-byte memory, so A1/A2 are consumed but not kept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg     <= '0;
      r_dir     <= 1'b0;
      r_space   <= '0;
      r_inc     <= 1'b0;
      r_crc_en  <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_crc     <= '0;
      r_crc_err <= 1'b0;
      for (int i = 0; i < 16; i++) r_scratch[i] <= '0;
    end else if (w_byte_vld && !w_idle_to) begin
      if (w_at_opc) begin
        r_reg <= w_byte[6:0];
        if (w_byte[7] && (w_byte[6:0] == 7'h05)) r_crc_err <= 1'b0;
      end else begin
        case (r_state)
          ST_WDATA: if (w_scratch_wr) r_scratch[r_reg[3:0]] <= w_byte;
          ST_SUB0: begin
            r_dir    <= w_byte[SUB0_DIR];
            r_space  <= w_byte[SUB0_SPACE_MSB:SUB0_SPACE_LSB];
            r_inc    <= w_byte[SUB0_INC];
            r_crc_en <= w_byte[SUB0_CRC];
            r_crc    <= '0;
          end
          ST_A0: r_addr       <= w_byte;
          ST_L0: r_len[7:0]   <= w_byte;
          ST_L1: r_len[15:8]  <= w_byte;
          ST_XDUMMY: begin
            r_crc <= crc8_update(r_crc, w_rd_byte);
            if (r_inc) r_addr <= r_addr + 8'd1;
          end
          ST_XRD: begin
            r_len <= r_len - 16'd1;
            if (!w_len_last) begin
              r_crc <= crc8_update(r_crc, w_rd_byte);
              if (r_inc) r_addr <= r_addr + 8'd1;
            end
          end
          ST_XWR: begin
            r_len <= r_len - 16'd1;
            r_crc <= crc8_update(r_crc, w_byte);
            if (r_inc) r_addr <= r_addr + 8'd1;
          end
          ST_XCRC: if (!r_dir && (w_byte != r_crc)) r_crc_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= w_byte;
    r_mem_q <= r_mem[r_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_esp32_spi_connector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_esp32_spi_connector : directed self-checking bench for esp32_spi_connector. Rev 1.0
// ----------------------------------------------------------------------------
module tb_esp32_spi_connector;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] rx;

  esp32_spi_connector_if spi ();

  esp32_spi_connector #(.USE_SYNC(1), .USE_CRC(1), .IDLE_TO_CYC(200)) dut (
    .clk (clk),
    .rst (rst),
    .spi (spi)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = tx[i];
      wait_clks(HALF);
      d[i] = spi.miso;
      spi.sclk = 1'b1;
      wait_clks(HALF);
      spi.sclk = 1'b0;
    end
    wait_clks(HALF);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    spi_byte(b, d);
  endtask

  task automatic preamble();
    send(8'hA5);
    send(8'h5A);
  endtask

  task automatic reg_wr(input logic [6:0] n, input logic [7:0] v);
    preamble();
    send({1'b0, n});
    send(v);
  endtask

  task automatic reg_rd(input logic [6:0] n, output logic [7:0] v);
    preamble();
    send({1'b1, n});
    spi_byte(8'h00, v);
  endtask

  task automatic xfer_hdr(input logic [7:0] sub0, input logic [7:0] addr, input logic [15:0] len);
    preamble();
    send(8'h7F);
    send(sub0);
    send(addr);
    send(8'h00);
    send(8'h00);
    send(len[7:0]);
    send(len[15:8]);
  endtask

  initial begin
    spi.sclk = 1'b0;
    spi.mosi = 1'b0;
    rst = 1'b1;
    wait_clks(6);
    rst = 1'b0;
    wait_clks(2);
    chk("reset_miso", spi.miso, 8'h00);

    reg_rd(7'h04, rx); chk("proto_ver", rx, 8'h01);
    reg_rd(7'h00, rx); chk("dev_id", rx, 8'hA2);
    reg_rd(7'h06, rx); chk("scratch06_reset", rx, 8'h00);
    reg_wr(7'h06, 8'h55);
    reg_rd(7'h06, rx); chk("scratch06_wr", rx, 8'h55);
    reg_wr(7'h0F, 8'h3C);
    reg_rd(7'h0F, rx); chk("scratch0f_wr", rx, 8'h3C);
    reg_wr(7'h01, 8'h77);
    reg_rd(7'h01, rx); chk("unmapped01", rx, 8'h00);
    reg_rd(7'h05, rx); chk("status_reset", rx, 8'h00);

    // Incrementing 4-byte write at 0x20, then read back
    xfer_hdr(8'h10, 8'h20, 16'd4);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    xfer_hdr(8'h11, 8'h20, 16'd4);
    send(8'h00);
    spi_byte(8'h00, rx); chk("xrd0", rx, 8'h01);
    spi_byte(8'h00, rx); chk("xrd1", rx, 8'h02);
    spi_byte(8'h00, rx); chk("xrd2", rx, 8'h03);
    spi_byte(8'h00, rx); chk("xrd3", rx, 8'h04);

    // No preamble: ignored entirely
    send(8'h84);
    spi_byte(8'h00, rx); chk("nosync_rd", rx, 8'h00);
    send(8'h06);
    send(8'h77);
    reg_rd(7'h06, rx); chk("nosync_no_wr", rx, 8'h55);

    // Idle timeout mid-byte must realign framing
    for (int i = 0; i < 4; i++) begin
      spi.mosi = 1'b1;
      wait_clks(HALF);
      spi.sclk = 1'b1;
      wait_clks(HALF);
      spi.sclk = 1'b0;
    end
    spi.mosi = 1'b0;
    wait_clks(300);
    reg_rd(7'h04, rx); chk("idle_realign", rx, 8'h01);

    // INC=0: last byte wins
    xfer_hdr(8'h00, 8'h30, 16'd4);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    xfer_hdr(8'h01, 8'h30, 16'd1);
    send(8'h00);
    spi_byte(8'h00, rx); chk("noinc_rd", rx, 8'hDD);

    // SPACE 1: write discarded, read returns zero
    xfer_hdr(8'h12, 8'h20, 16'd1);
    send(8'hEE);
    xfer_hdr(8'h11, 8'h20, 16'd1);
    send(8'h00);
    spi_byte(8'h00, rx); chk("space1_wr_discard", rx, 8'h01);
    xfer_hdr(8'h03, 8'h20, 16'd1);
    send(8'h00);
    spi_byte(8'h00, rx); chk("space1_rd_zero", rx, 8'h00);

    // LEN=0 returns to HUNT right after L1
    xfer_hdr(8'h10, 8'h20, 16'd0);
    reg_rd(7'h04, rx); chk("len0_hunt", rx, 8'h01);
    xfer_hdr(8'h11, 8'h20, 16'd1);
    send(8'h00);
    spi_byte(8'h00, rx); chk("len0_no_wr", rx, 8'h01);

    // CRC-8 of 0x12 is 0x7E
    xfer_hdr(8'h30, 8'h40, 16'd1);
    send(8'h12); send(8'h7E);
    reg_rd(7'h05, rx); chk("crc_good_status", rx, 8'h00);
    xfer_hdr(8'h30, 8'h40, 16'd1);
    send(8'h12); send(8'h00);
    reg_rd(7'h05, rx); chk("crc_bad_status", rx, 8'h01);
    reg_rd(7'h05, rx); chk("crc_status_clr", rx, 8'h00);
    xfer_hdr(8'h31, 8'h40, 16'd1);
    send(8'h00);
    spi_byte(8'h00, rx); chk("crc_rd_data", rx, 8'h12);
    spi_byte(8'h00, rx); chk("crc_rd_trailer", rx, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
